dl_mem_arbiter: RTL and testbench
=================================

DL_MEM_ARBITER -- requirements
Module: dl_mem_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, is the number of download writes buffered (power of two, at least 2).
REQ-002 Parameter RELEASE_CYCLES, default 16, is the number of cycles game_reset stays high after the download drains.
REQ-003 Parameter WR_BURST_MAX, default 8, is the number of consecutive writes granted while a CPU read is pending.
REQ-004 clk_sys  in  1  single clock; all logic on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 dn_download  in  1  HPS download in progress.
REQ-007 dn_wr  in  1  one-cycle write strobe from HPS.
REQ-008 dn_addr  in  16  download byte address.
REQ-009 dn_data  in  8  download byte.
REQ-010 cpu_req  in  1  game read request, level, held until cpu_ack.
REQ-011 cpu_addr  in  16  game read address, stable while cpu_req is high.
REQ-012 cpu_ack  out  1  one-cycle pulse; cpu_data is valid in that cycle.
REQ-013 cpu_data  out  8  read data, held until the next cpu_ack.
REQ-014 mem_addr  out  16  shared single-port RAM address.
REQ-015 mem_we  out  1  RAM write enable.
REQ-016 mem_din  out  8  RAM write data.
REQ-017 mem_dout  in  8  RAM read data, valid one cycle after mem_addr.
REQ-018 game_reset  out  1  active-high reset to the game core.
REQ-019 dn_overflow  out  1  sticky flag: a download write was dropped.

Function
REQ-020 Each dn_wr pulse SHALL push {dn_addr, dn_data} into the write FIFO in the same cycle.
REQ-021 dn_wr arriving while the FIFO is full with no pop in that cycle SHALL be dropped and SHALL set dn_overflow.
REQ-022 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-023 The FSM SHALL have three states: IDLE, RD_ADDR and RD_DATA.
REQ-024 In IDLE with the FIFO non-empty, the arbiter SHALL pop one entry and drive mem_we=1, mem_addr and mem_din for exactly that cycle, then remain in IDLE.
REQ-025 In IDLE, cpu_req SHALL win over a non-empty FIFO only when the FIFO is empty or the write-burst counter equals WR_BURST_MAX.
REQ-026 The write-burst counter SHALL increment on each write granted while cpu_req=1 and SHALL clear on each read grant.
REQ-027 A read grant SHALL move IDLE to RD_ADDR with mem_addr=cpu_addr and mem_we=0.
REQ-028 RD_ADDR SHALL move unconditionally to RD_DATA.
REQ-029 In RD_DATA the block SHALL capture mem_dout into cpu_data, pulse cpu_ack and return to IDLE; read latency from grant to cpu_ack SHALL be 2 cycles.
REQ-030 Once a read is granted it SHALL complete and ack even if cpu_req drops mid-transaction.
REQ-031 game_reset SHALL be 1 while dn_download=1 or the FIFO is non-empty.
REQ-032 After both conditions clear, game_reset SHALL stay 1 for exactly RELEASE_CYCLES further cycles, then fall.
REQ-033 A new dn_download rise during the release countdown SHALL reload the countdown and keep game_reset at 1.
REQ-034 mem_we SHALL never be 1 in RD_ADDR or RD_DATA.

Reset
REQ-035 With reset_n=0, all of the following SHALL hold: state=IDLE, FIFO empty, burst counter=0, cpu_ack=0, cpu_data=0, mem_we=0, mem_addr=0, mem_din=0, dn_overflow=0, game_reset=1, release counter=RELEASE_CYCLES.
REQ-036 Reset asserted mid-read SHALL abort the read with no cpu_ack.
REQ-037 Reset asserted with entries buffered SHALL discard them.

Structure
REQ-038 A shared package SHALL hold the FSM state enum and the default parameter constants.
REQ-039 The write FIFO SHALL be one sub-module, dl_wr_fifo: synchronous, with push/pop/full/empty and first-word-fall-through output.

Verification
REQ-040 Scenario: reset release with no activity -> game_reset=1 for RELEASE_CYCLES=16 cycles, then 0; mem_we stays 0.
REQ-041 Scenario: 3 dn_wr pulses (addr 0x0000-0x0002, data 0xA5/0x5A/0xFF) on consecutive cycles -> 3 mem_we cycles in order with matching addr/data; dn_overflow=0.
REQ-042 Scenario: 6 back-to-back dn_wr pulses while cpu_req is held -> no drops (pop keeps pace); cpu_ack arrives only after the writes drain.
REQ-043 Scenario: cpu_req at addr 0x1234 with RAM holding 0x3C and the FIFO empty -> cpu_ack exactly 2 cycles after grant with cpu_data=0x3C.
REQ-044 Scenario: FIFO full while a read is in progress, then another dn_wr -> that write is dropped and dn_overflow=1 until reset.
REQ-045 Scenario: dn_download re-asserted at countdown cycle 10 -> game_reset stays 1 and the full 16-cycle countdown restarts after the drain.

Source files
------------

// File: rtl/dl_mem_arbiter_pkg.sv
// Shared types and default constants for the download / CPU-read memory arbiter.
// The FSM state enum and the buffered write-entry layout live here.
package dl_mem_arbiter_pkg;

  localparam int ADDR_W             = 16;
  localparam int DATA_W             = 8;
  localparam int FIFO_DEPTH_DEF     = 4;
  localparam int RELEASE_CYCLES_DEF = 16;
  localparam int WR_BURST_MAX_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_ADDR = 2'd1,
    ST_RD_DATA = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/dl_mem_arbiter_if.sv
// Bundle of download, CPU-read, RAM-port and status signals around the arbiter.
// master = the surrounding system (HPS, game core, RAM); slave = the arbiter.
interface dl_mem_arbiter_if;
  import dl_mem_arbiter_pkg::*;

  logic              dn_download;
  logic              dn_wr;
  logic [ADDR_W-1:0] dn_addr;
  logic [DATA_W-1:0] dn_data;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              game_reset;
  logic              dn_overflow;

  modport master (
    output dn_download, dn_wr, dn_addr, dn_data, cpu_req, cpu_addr, mem_dout,
    input  cpu_ack, cpu_data, mem_addr, mem_we, mem_din, game_reset, dn_overflow
  );

  modport slave (
    input  dn_download, dn_wr, dn_addr, dn_data, cpu_req, cpu_addr, mem_dout,
    output cpu_ack, cpu_data, mem_addr, mem_we, mem_din, game_reset, dn_overflow
  );

endinterface

// File: rtl/dl_wr_fifo.sv
// Synchronous first-word-fall-through FIFO for buffered download writes.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module dl_wr_fifo
  import dl_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic      clk_sys,
  input  logic      reset_n,
  input  logic      push_i,
  input  logic      pop_i,
  input  wr_entry_t data_i,
  output wr_entry_t data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(DEPTH);

  wr_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are valid.
  always_ff @(posedge clk_sys) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dl_mem_arbiter.sv
// Arbitrates a single-port RAM between buffered HPS download writes and game CPU
// reads, and holds the game core in reset until the download has settled.
//
// state      | meaning
// ST_IDLE    | pop one buffered write per cycle, or grant a pending CPU read
// ST_RD_ADDR | read address held on the RAM, data for it appears next cycle
// ST_RD_DATA | RAM data returned to the CPU with a one-cycle cpu_ack
module dl_mem_arbiter
  import dl_mem_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter int RELEASE_CYCLES = RELEASE_CYCLES_DEF,
  parameter int WR_BURST_MAX   = WR_BURST_MAX_DEF
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  dl_mem_arbiter_if.slave bus
);

  localparam int                BURST_W   = $clog2(WR_BURST_MAX + 1);
  localparam int                REL_W     = $clog2(RELEASE_CYCLES + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(WR_BURST_MAX);
  localparam logic [REL_W-1:0]  REL_LOAD  = REL_W'(RELEASE_CYCLES);

  arb_state_e        state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
  logic              ovf_q, ovf_d;
  logic [REL_W-1:0]  rel_cnt_q, rel_cnt_d;

  wr_entry_t         push_entry, head;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic              busy;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              cpu_ack;

  assign push_entry = '{addr: bus.dn_addr, data: bus.dn_data};

  dl_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push_i  (bus.dn_wr),
    .pop_i   (fifo_pop),
    .data_i  (push_entry),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    rd_addr_d  = rd_addr_q;
    cpu_data_d = cpu_data_q;
    fifo_pop   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    cpu_ack    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Writes normally win; a waiting read gets in once the burst quota is used up.
        if (bus.cpu_req && (fifo_empty || burst_q == BURST_MAX)) begin
          state_d   = ST_RD_ADDR;
          burst_d   = '0;
          rd_addr_d = bus.cpu_addr;
          mem_addr  = bus.cpu_addr;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          mem_we   = 1'b1;
          mem_addr = head.addr;
          mem_din  = head.data;
          if (bus.cpu_req) burst_d = burst_q + BURST_W'(1);
        end
      end
      ST_RD_ADDR: begin
        mem_addr = rd_addr_q;
        state_d  = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        mem_addr   = rd_addr_q;
        cpu_ack    = 1'b1;
        cpu_data_d = bus.mem_dout;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!reset_n) begin
      fifo_pop = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      cpu_ack  = 1'b0;
    end
  end

  assign busy  = bus.dn_download || !fifo_empty;
  assign ovf_d = ovf_q || (bus.dn_wr && fifo_full && !fifo_pop);

  always_comb begin
    rel_cnt_d = rel_cnt_q;
    if (busy)                 rel_cnt_d = REL_LOAD;
    else if (rel_cnt_q != '0) rel_cnt_d = rel_cnt_q - REL_W'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      burst_q    <= '0;
      rd_addr_q  <= '0;
      cpu_data_q <= '0;
      ovf_q      <= 1'b0;
      rel_cnt_q  <= REL_LOAD;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      rd_addr_q  <= rd_addr_d;
      cpu_data_q <= cpu_data_d;
      ovf_q      <= ovf_d;
      rel_cnt_q  <= rel_cnt_d;
    end
  end

  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_din     = mem_din;
  assign bus.cpu_ack     = cpu_ack;
  // RAM data is forwarded during the ack cycle and held in cpu_data_q afterwards.
  assign bus.cpu_data    = !reset_n ? '0 : (cpu_ack ? bus.mem_dout : cpu_data_q);
  assign bus.dn_overflow = reset_n && ovf_q;
  assign bus.game_reset  = !reset_n || busy || (rel_cnt_q != '0);

endmodule

// File: tb/tb_dl_mem_arbiter.sv
// Directed bench for dl_mem_arbiter: bench-side RAM model, write log and
// hand-computed expectations for each scenario.
module tb_dl_mem_arbiter;
  import dl_mem_arbiter_pkg::*;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  dl_mem_arbiter_if bif ();

  dl_mem_arbiter #(
    .FIFO_DEPTH     (4),
    .RELEASE_CYCLES (16),
    .WR_BURST_MAX   (8)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bif)
  );

  logic [7:0]  ram [0:65535];
  logic [23:0] wlog [$];
  int          ack_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  pat [3] = '{8'hA5, 8'h5A, 8'hFF};

  always @(posedge clk_sys) begin
    if (bif.mem_we) ram[bif.mem_addr] <= bif.mem_din;
    bif.mem_dout <= ram[bif.mem_addr];
    if (bif.mem_we) wlog.push_back({bif.mem_addr, bif.mem_din});
    if (bif.cpu_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk_sys);
      if (bif.cpu_ack) break;
      n++;
      tick();
    end
  endtask

  task automatic measure_release(output int n);
    n = 0;
    while (n < 64) begin
      @(negedge clk_sys);
      if (!bif.game_reset) break;
      n++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int acks0;
    logic hi_ok;

    ram = '{default: 8'h00};
    ram[16'h1234] = 8'h3C;
    bif.dn_download = 1'b0;
    bif.dn_wr       = 1'b0;
    bif.dn_addr     = '0;
    bif.dn_data     = '0;
    bif.cpu_req     = 1'b0;
    bif.cpu_addr    = '0;

    // Reset values
    repeat (3) tick();
    @(negedge clk_sys);
    chk("rst_game_reset", 32'(bif.game_reset), 32'd1);
    chk("rst_mem_we", 32'(bif.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bif.mem_addr), 32'd0);
    chk("rst_cpu_ack", 32'(bif.cpu_ack), 32'd0);
    chk("rst_overflow", 32'(bif.dn_overflow), 32'd0);
    tick();
    reset_n = 1'b1;
    measure_release(n);
    chk("release_after_reset", 32'(n), 32'd16);
    chk("no_writes_idle", 32'(wlog.size()), 32'd0);
    tick();

    // Three ordered download writes
    bif.dn_download = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bif.dn_wr   = 1'b1;
      bif.dn_addr = 16'(i);
      bif.dn_data = pat[i];
      tick();
    end
    bif.dn_wr = 1'b0;
    repeat (3) tick();
    @(negedge clk_sys);
    chk("wr3_count", 32'(wlog.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("wr3_entry", 32'(wlog[i]), 32'({16'(i), pat[i]}));
    chk("wr3_overflow", 32'(bif.dn_overflow), 32'd0);
    chk("wr3_game_reset", 32'(bif.game_reset), 32'd1);
    bif.dn_download = 1'b0;
    tick();

    // Plain read, FIFO empty
    bif.cpu_req  = 1'b1;
    bif.cpu_addr = 16'h1234;
    wait_ack(n);
    chk("rd_latency", 32'(n), 32'd2);
    chk("rd_data", 32'(bif.cpu_data), 32'h3C);
    tick();
    bif.cpu_req = 1'b0;
    @(negedge clk_sys);
    chk("rd_data_held", 32'(bif.cpu_data), 32'h3C);
    chk("rd_ack_single", 32'(bif.cpu_ack), 32'd0);
    tick();

    // cpu_req dropped after grant still completes
    bif.cpu_req  = 1'b1;
    bif.cpu_addr = 16'h0001;
    tick();
    bif.cpu_req = 1'b0;
    wait_ack(n);
    chk("rd_drop_latency", 32'(n), 32'd1);
    chk("rd_drop_data", 32'(bif.cpu_data), 32'h5A);
    repeat (3) tick();

    // Six writes with a read pending: writes drain first
    wlog.delete();
    acks0 = ack_cnt;
    bif.dn_download = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bif.dn_wr   = 1'b1;
      bif.dn_addr = 16'(32'h0100 + i);
      bif.dn_data = 8'(32'h10 + i);
      if (i == 1) begin
        bif.cpu_req  = 1'b1;
        bif.cpu_addr = 16'h0002;
      end
      tick();
    end
    bif.dn_wr = 1'b0;
    wait_ack(n);
    chk("burst_ack_after_drain", 32'(n), 32'd3);
    chk("burst_writes_done", 32'(wlog.size()), 32'd6);
    chk("burst_first_wr", 32'(wlog[0]), 32'h0100_10);
    chk("burst_last_wr", 32'(wlog[5]), 32'h0105_15);
    chk("burst_rd_data", 32'(bif.cpu_data), 32'hFF);
    chk("burst_no_early_ack", 32'(ack_cnt - acks0), 32'd0);
    tick();
    bif.cpu_req = 1'b0;
    chk("burst_overflow", 32'(bif.dn_overflow), 32'd0);
    bif.dn_download = 1'b0;
    repeat (3) tick();

    // Continuous writes with continuous reads: burst quota, full FIFO, drop
    wlog.delete();
    bif.dn_download = 1'b1;
    bif.cpu_req     = 1'b1;
    bif.cpu_addr    = 16'h1234;
    for (int i = 0; i < 14; i++) begin
      bif.dn_wr   = 1'b1;
      bif.dn_addr = 16'(32'h0200 + i);
      bif.dn_data = 8'(i);
      @(negedge clk_sys);
      if (i == 2)  chk("ovf_ack_first", 32'(bif.cpu_ack), 32'd1);
      if (i == 10) chk("ovf_we_last_burst", 32'(bif.mem_we), 32'd1);
      if (i >= 11) chk("ovf_we_during_read", 32'(bif.mem_we), 32'd0);
      if (i == 12) chk("ovf_not_yet", 32'(bif.dn_overflow), 32'd0);
      if (i == 13) begin
        chk("ovf_set", 32'(bif.dn_overflow), 32'd1);
        chk("ovf_ack_second", 32'(bif.cpu_ack), 32'd1);
        chk("ovf_rd_data", 32'(bif.cpu_data), 32'h3C);
      end
      tick();
    end
    bif.dn_wr   = 1'b0;
    bif.cpu_req = 1'b0;
    repeat (10) tick();
    @(negedge clk_sys);
    chk("ovf_sticky", 32'(bif.dn_overflow), 32'd1);
    chk("ovf_accepted_writes", 32'(wlog.size()), 32'd12);
    chk("ovf_last_accepted", 32'(wlog[wlog.size()-1]), 32'h020B_0B);
    bif.dn_download = 1'b0;
    tick();

    // Reset during a read with an entry buffered
    wlog.delete();
    acks0 = ack_cnt;
    bif.cpu_req  = 1'b1;
    bif.cpu_addr = 16'h0000;
    bif.dn_wr    = 1'b1;
    bif.dn_addr  = 16'h0300;
    bif.dn_data  = 8'hEE;
    tick();
    reset_n     = 1'b0;
    bif.dn_addr = 16'h0301;
    tick();
    bif.dn_wr   = 1'b0;
    bif.cpu_req = 1'b0;
    @(negedge clk_sys);
    chk("rst2_cpu_ack", 32'(bif.cpu_ack), 32'd0);
    chk("rst2_cpu_data", 32'(bif.cpu_data), 32'd0);
    chk("rst2_mem_we", 32'(bif.mem_we), 32'd0);
    chk("rst2_mem_din", 32'(bif.mem_din), 32'd0);
    chk("rst2_overflow", 32'(bif.dn_overflow), 32'd0);
    chk("rst2_game_reset", 32'(bif.game_reset), 32'd1);
    tick();
    reset_n = 1'b1;
    repeat (20) tick();
    chk("rst2_read_aborted", 32'(ack_cnt - acks0), 32'd0);
    chk("rst2_fifo_discarded", 32'(wlog.size()), 32'd0);

    // Download re-asserted during the release countdown
    bif.dn_download = 1'b1;
    bif.dn_wr       = 1'b1;
    bif.dn_addr     = 16'h0400;
    bif.dn_data     = 8'h77;
    tick();
    bif.dn_wr = 1'b0;
    tick();
    tick();
    bif.dn_download = 1'b0;
    hi_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      if (!bif.game_reset) hi_ok = 1'b0;
      tick();
    end
    bif.dn_download = 1'b1;
    @(negedge clk_sys);
    if (!bif.game_reset) hi_ok = 1'b0;
    tick();
    tick();
    bif.dn_download = 1'b0;
    measure_release(n);
    chk("restart_held_high", 32'(hi_ok), 32'd1);
    chk("restart_full_countdown", 32'(n), 32'd16);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
